// File: rtl/bmp_stream_loader.sv
// Streams a 24/32-bpp Windows BMP from data_io into a linear framebuffer of
// {8'h00,R,G,B} words, rows stored top-to-bottom, through a small write FIFO.
module bmp_stream_loader #(
  parameter int ADDR_W      = 22,
  parameter int STRIDE_LOG2 = 9,
  parameter int MAX_W       = 640,
  parameter int MAX_H       = 480,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic              busy,
  output logic              loaded,
  output logic [4:0]        error
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MAX_W_L  = MAX_W;
  localparam logic [31:0] MAX_H_L  = MAX_H;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SKIP, S_PIXEL, S_PAD, S_DONE, S_ERROR
  } state_t;

  state_t state, state_next;

  logic        wr_prev, dl_prev;
  logic [31:0] data_off;
  logic [23:0] hgt_lo;
  logic [7:0]  bpp_lo;
  logic        bpp32, top_down, height_big;
  logic [15:0] x, y, row_cnt;
  logic [1:0]  bidx, pad_cnt;
  logic [7:0]  b_byte, g_byte, r_byte;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       cnt;

  logic        strobe, dl_rise, dl_fall, hdr_strobe, at29;
  logic        sig_bad, off_bad, fmt_bad, size_bad, err_any;
  logic        pix_take, pix_last, row_end, last_row, pad_last, push;
  logic        full, pop, do_push, overflow;
  logic [1:0]  pad_n;
  logic [31:0] h_full, h_abs;
  logic [15:0] bpp_val;
  logic [ADDR_W-1:0] push_addr;
  logic [31:0]       push_data;
  logic        clear_all, trunc, finish, busy_off;

  assign strobe     = ioctl_wr & ~wr_prev & ioctl_download;
  assign dl_rise    = ioctl_download & ~dl_prev;
  assign dl_fall    = ~ioctl_download & dl_prev;
  assign hdr_strobe = strobe && (state == S_HEADER);
  assign at29       = hdr_strobe && (ioctl_addr == 25'd29);

  assign sig_bad = hdr_strobe &&
                   (((ioctl_addr == 25'd0) && (ioctl_dout != 8'h42)) ||
                    ((ioctl_addr == 25'd1) && (ioctl_dout != 8'h4D)));
  assign off_bad = hdr_strobe && (ioctl_addr == 25'd13) && (ioctl_dout != 8'h00);

  assign h_full  = {ioctl_dout, hgt_lo};
  assign h_abs   = h_full[31] ? (32'd0 - h_full) : h_full;
  assign bpp_val = {ioctl_dout, bpp_lo};

  assign fmt_bad  = at29 && (((bpp_val != 16'd24) && (bpp_val != 16'd32)) ||
                             (data_off < 32'd30));
  assign size_bad = at29 && ((img_width == 16'd0) || (32'(img_width) > MAX_W_L) ||
                             (img_height == 16'd0) || height_big);
  assign err_any  = (error != 5'd0) || fmt_bad || size_bad;

  // The byte at data_off is consumed while still in SKIP so no byte is lost.
  assign pix_take = strobe && ((state == S_PIXEL) ||
                               ((state == S_SKIP) && ({7'd0, ioctl_addr} == data_off)));
  assign pix_last = bpp32 ? (bidx == 2'd3) : (bidx == 2'd2);
  assign push     = pix_take && pix_last;
  assign row_end  = (x == img_width - 16'd1);
  assign last_row = (row_cnt == img_height - 16'd1);
  assign pad_n    = bpp32 ? 2'd0 : img_width[1:0];
  assign pad_last = (pad_cnt == pad_n - 2'd1);

  assign push_addr = (ADDR_W'(y) << STRIDE_LOG2) + ADDR_W'(x);
  assign push_data = {8'h00, (bpp32 ? r_byte : ioctl_dout), g_byte, b_byte};

  assign full     = (cnt == CNT_FULL);
  assign wr_valid = (cnt != {(PW+1){1'b0}});
  assign pop      = wr_valid & wr_ready;
  assign do_push  = push & (~full | pop);
  assign overflow = push & full & ~pop;
  assign wr_addr  = wr_valid ? addr_mem[rp] : {ADDR_W{1'b0}};
  assign wr_data  = wr_valid ? data_mem[rp] : 32'd0;

  // Parser state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and one-cycle control pulses.
  always_comb begin
    state_next = state;
    clear_all  = 1'b0;
    trunc      = 1'b0;
    finish     = 1'b0;
    busy_off   = 1'b0;
    if (dl_rise) begin
      state_next = S_HEADER;
      clear_all  = 1'b1;
    end else begin
      case (state)
        S_IDLE: state_next = S_IDLE;
        S_HEADER: begin
          if (dl_fall) begin
            state_next = S_IDLE;
            trunc      = 1'b1;
          end else if (sig_bad) begin
            state_next = S_ERROR;
          end else if (at29) begin
            state_next = err_any ? S_ERROR : S_SKIP;
          end else begin
            state_next = S_HEADER;
          end
        end
        S_SKIP: begin
          if (dl_fall) begin
            state_next = S_IDLE;
            trunc      = 1'b1;
          end else if (pix_take) begin
            state_next = S_PIXEL;
          end else begin
            state_next = S_SKIP;
          end
        end
        S_PIXEL: begin
          if (dl_fall) begin
            state_next = S_IDLE;
            trunc      = 1'b1;
          end else if (push && row_end) begin
            if (last_row) begin
              state_next = S_DONE;
            end else if (pad_n != 2'd0) begin
              state_next = S_PAD;
            end else begin
              state_next = S_PIXEL;
            end
          end else begin
            state_next = S_PIXEL;
          end
        end
        S_PAD: begin
          if (dl_fall) begin
            state_next = S_IDLE;
            trunc      = 1'b1;
          end else if (strobe && pad_last) begin
            state_next = S_PIXEL;
          end else begin
            state_next = S_PAD;
          end
        end
        S_DONE: begin
          if (!ioctl_download && !wr_valid) begin
            state_next = S_IDLE;
            finish     = 1'b1;
          end else begin
            state_next = S_DONE;
          end
        end
        S_ERROR: begin
          if (dl_fall) begin
            state_next = S_IDLE;
            busy_off   = 1'b1;
          end else begin
            state_next = S_ERROR;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Edge detectors for the byte strobe and download window.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_prev <= 1'b0;
      dl_prev <= 1'b0;
    end else begin
      wr_prev <= ioctl_wr;
      dl_prev <= ioctl_download;
    end
  end

  // Header fields, pixel assembly, counters, flags and FIFO pointers.
  always_ff @(posedge clk_sys) begin
    if (reset || clear_all) begin
      data_off   <= 32'd0;
      hgt_lo     <= 24'd0;
      bpp_lo     <= 8'd0;
      bpp32      <= 1'b0;
      top_down   <= 1'b0;
      height_big <= 1'b0;
      x          <= 16'd0;
      y          <= 16'd0;
      row_cnt    <= 16'd0;
      bidx       <= 2'd0;
      pad_cnt    <= 2'd0;
      b_byte     <= 8'd0;
      g_byte     <= 8'd0;
      r_byte     <= 8'd0;
      img_width  <= 16'd0;
      img_height <= 16'd0;
      error      <= 5'd0;
      loaded     <= 1'b0;
      busy       <= ~reset;
      wp         <= {PW{1'b0}};
      rp         <= {PW{1'b0}};
      cnt        <= {(PW+1){1'b0}};
    end else begin
      if (hdr_strobe) begin
        case (ioctl_addr)
          25'd10: data_off[7:0]    <= ioctl_dout;
          25'd11: data_off[15:8]   <= ioctl_dout;
          25'd12: data_off[23:16]  <= ioctl_dout;
          25'd13: data_off[31:24]  <= ioctl_dout;
          25'd18: img_width[7:0]   <= ioctl_dout;
          25'd19: img_width[15:8]  <= ioctl_dout;
          25'd22: hgt_lo[7:0]      <= ioctl_dout;
          25'd23: hgt_lo[15:8]     <= ioctl_dout;
          25'd24: hgt_lo[23:16]    <= ioctl_dout;
          25'd25: begin
            img_height <= h_abs[15:0];
            top_down   <= ioctl_dout[7];
            height_big <= (h_abs > MAX_H_L);
          end
          25'd28: bpp_lo <= ioctl_dout;
          25'd29: begin
            bpp32 <= (bpp_val == 16'd32);
            y     <= top_down ? 16'd0 : (img_height - 16'd1);
          end
          default: ;
        endcase
      end

      error <= error | {trunc, overflow, size_bad, fmt_bad | off_bad, sig_bad};

      if (pix_take) begin
        case (bidx)
          2'd0:    b_byte <= ioctl_dout;
          2'd1:    g_byte <= ioctl_dout;
          2'd2:    r_byte <= ioctl_dout;
          default: ;
        endcase
        bidx <= pix_last ? 2'd0 : (bidx + 2'd1);
      end

      if (push) begin
        if (row_end) begin
          x       <= 16'd0;
          row_cnt <= row_cnt + 16'd1;
          y       <= top_down ? (y + 16'd1) : (y - 16'd1);
        end else begin
          x <= x + 16'd1;
        end
      end

      if (strobe && (state == S_PAD)) begin
        pad_cnt <= pad_last ? 2'd0 : (pad_cnt + 2'd1);
      end

      if (trunc || busy_off || finish) begin
        busy <= 1'b0;
      end
      if (finish) begin
        loaded <= 1'b1;
      end

      if (trunc) begin
        wp  <= {PW{1'b0}};
        rp  <= {PW{1'b0}};
        cnt <= {(PW+1){1'b0}};
      end else begin
        if (do_push) begin
          wp <= wp + PW'(1);
        end
        if (pop) begin
          rp <= rp + PW'(1);
        end
        if (do_push && !pop) begin
          cnt <= cnt + (PW+1)'(1);
        end else if (!do_push && pop) begin
          cnt <= cnt - (PW+1)'(1);
        end
      end
    end
  end

  // FIFO storage; entries past the read pointer are never observed.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      addr_mem[wp] <= push_addr;
      data_mem[wp] <= push_data;
    end
  end

endmodule

// File: tb/tb_bmp_stream_loader.sv
// Bench for bmp_stream_loader: table of header cases, random images checked
// against a file-layout model, plus overflow, truncation and reset sequences.
module tb_bmp_stream_loader;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, wr_ready;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        wr_valid, busy, loaded;
  logic [21:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] img_width, img_height;
  logic [4:0]  error;

  always #5 clk_sys = ~clk_sys;

  bmp_stream_loader #(.ADDR_W(22), .STRIDE_LOG2(9), .MAX_W(640), .MAX_H(480),
                      .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .img_width(img_width), .img_height(img_height), .busy(busy), .loaded(loaded),
    .error(error));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;
  logic [7:0]  file_q[$];
  logic [53:0] exp_q[$];
  logic [53:0] got_q[$];
  logic        stall_prev = 1'b0;
  logic [53:0] stall_word;

  typedef struct {
    int         w;
    int         h;
    int         bpp;
    int         off;
    logic [7:0] b0;
    logic [4:0] err;
    logic       ld;
  } vec_t;
  vec_t tv[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // sink: record accepted writes and check the head holds while stalled
  always @(negedge clk_sys) begin
    if (wr_valid && stall_prev)
      check("hold_stable", 32'({wr_addr, wr_data} == stall_word), 32'd1);
    if (wr_valid && wr_ready)
      got_q.push_back({wr_addr, wr_data});
    stall_prev <= wr_valid && !wr_ready;
    stall_word <= {wr_addr, wr_data};
  end

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(0, 3) != 0);
        default: wr_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic build_file(input int w, input int h, input int bpp, input int off,
                            input logic [7:0] b0, input bit valid);
    int habs, rowb, nbytes;
    logic [31:0] hv, ov;
    file_q.delete();
    habs   = (h < 0) ? -h : h;
    rowb   = ((w * bpp / 8) + 3) / 4 * 4;
    nbytes = valid ? off + rowb * habs : 34;
    for (int i = 0; i < nbytes; i++) file_q.push_back(8'($urandom_range(0, 255)));
    hv = 32'(h);
    ov = 32'(off);
    file_q[0] = b0;
    file_q[1] = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      file_q[10 + k] = ov[8*k +: 8];
      file_q[22 + k] = hv[8*k +: 8];
    end
    file_q[18] = 8'(w);
    file_q[19] = 8'(w >> 8);
    file_q[28] = 8'(bpp);
    file_q[29] = 8'(bpp >> 8);
  endtask

  // expected writes straight from the file layout: row r of the file maps to
  // line r (top-down) or habs-1-r (bottom-up); rows are padded to 4 bytes
  task automatic build_exp(input int w, input int h, input int bpp, input int off);
    int habs, rowb, base, yy;
    exp_q.delete();
    habs = (h < 0) ? -h : h;
    rowb = ((w * bpp / 8) + 3) / 4 * 4;
    for (int r = 0; r < habs; r++) begin
      for (int xx = 0; xx < w; xx++) begin
        base = off + r * rowb + xx * (bpp / 8);
        yy   = (h < 0) ? r : habs - 1 - r;
        exp_q.push_back({22'(yy * 512 + xx), 8'h00, file_q[base + 2], file_q[base + 1],
                         file_q[base]});
      end
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk_sys);
    #1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic send(input int trunc, input int rmode, input int off);
    int n, cyc;
    got_q.delete();
    ready_mode = rmode;
    @(posedge clk_sys);
    #1;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    n = (trunc < 0) ? file_q.size() : trunc;
    for (int i = 0; i < n; i++) begin
      send_byte(25'(i), file_q[i]);
      if (rmode == 2 && i == off + 1) check("latency_pre", 32'(wr_valid), 32'd0);
      if (rmode == 2 && i == off + 2) check("latency_push", 32'(wr_valid), 32'd1);
    end
    repeat (2) @(posedge clk_sys);
    #1;
    ioctl_download = 1'b0;
    if (rmode == 2) begin
      repeat (3) @(posedge clk_sys);
      ready_mode = 0;
    end
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk_sys);
      cyc++;
    end
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_result(input logic [4:0] e, input logic ld, input int w, input int habs);
    int n;
    check("error", 32'(error), 32'(e));
    check("loaded", 32'(loaded), 32'(ld));
    check("busy_end", 32'(busy), 32'd0);
    check("fifo_empty", 32'(wr_valid), 32'd0);
    if (ld) begin
      check("img_width", 32'(img_width), 32'(w));
      check("img_height", 32'(img_height), 32'(habs));
    end
    check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", 32'(got_q[i][53:32]), 32'(exp_q[i][53:32]));
      check("wr_data", got_q[i][31:0], exp_q[i][31:0]);
    end
  endtask

  initial begin
    int w, h, bpp, off;
    bit valid;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0;

    tv[0]  = '{2,    2,    24, 54,           8'h42, 5'd0, 1'b1};
    tv[1]  = '{3,   -1,    32, 70,           8'h42, 5'd0, 1'b1};
    tv[2]  = '{2,    2,    24, 54,           8'h41, 5'd1, 1'b0};
    tv[3]  = '{2,    2,    16, 54,           8'h42, 5'd2, 1'b0};
    tv[4]  = '{641,  2,    24, 54,           8'h42, 5'd4, 1'b0};
    tv[5]  = '{5,    3,    24, 54,           8'h42, 5'd0, 1'b1};
    tv[6]  = '{7,   -2,    24, 60,           8'h42, 5'd0, 1'b1};
    tv[7]  = '{4,    0,    24, 54,           8'h42, 5'd4, 1'b0};
    tv[8]  = '{4,   -481,  32, 54,           8'h42, 5'd4, 1'b0};
    tv[9]  = '{1,    1,    32, 30,           8'h42, 5'd0, 1'b1};
    tv[10] = '{2,    2,    24, 29,           8'h42, 5'd2, 1'b0};
    tv[11] = '{2,    2,    24, 32'h01000036, 8'h42, 5'd2, 1'b0};
    tv[12] = '{640,  1,    32, 54,           8'h42, 5'd0, 1'b1};
    tv[13] = '{1,   -480,  24, 54,           8'h42, 5'd0, 1'b1};
    tv[14] = '{0,    2,    24, 54,           8'h42, 5'd4, 1'b0};

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dims", {img_width, img_height}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);

    for (int i = 0; i < 15; i++) begin
      valid = (tv[i].err == 5'd0);
      build_file(tv[i].w, tv[i].h, tv[i].bpp, tv[i].off, tv[i].b0, valid);
      if (i == 0) begin
        file_q[54] = 8'h10; file_q[55] = 8'h20; file_q[56] = 8'h30;
      end
      exp_q.delete();
      if (valid) build_exp(tv[i].w, tv[i].h, tv[i].bpp, tv[i].off);
      send(-1, 0, tv[i].off);
      check_result(tv[i].err, tv[i].ld, tv[i].w, (tv[i].h < 0) ? -tv[i].h : tv[i].h);
      if (i == 0) begin
        check("tp_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() >= 4) begin
          check("tp_addr0", 32'(got_q[0][53:32]), 32'd512);
          check("tp_data0", got_q[0][31:0], 32'h00302010);
          check("tp_addr1", 32'(got_q[1][53:32]), 32'd513);
          check("tp_addr2", 32'(got_q[2][53:32]), 32'd0);
          check("tp_addr3", 32'(got_q[3][53:32]), 32'd1);
        end
      end
    end

    for (int i = 0; i < 8; i++) begin
      w   = $urandom_range(1, 9);
      h   = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) h = -h;
      bpp = ($urandom_range(0, 1) == 1) ? 32 : 24;
      off = $urandom_range(30, 90);
      build_file(w, h, bpp, off, 8'h42, 1'b1);
      build_exp(w, h, bpp, off);
      send(-1, 1, off);
      check_result(5'd0, 1'b1, w, (h < 0) ? -h : h);
    end

    // overflow: six pixels into a four-deep FIFO with the sink stalled
    build_file(3, 2, 24, 54, 8'h42, 1'b1);
    build_exp(3, 2, 24, 54);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    send(-1, 2, 54);
    check_result(5'd8, 1'b1, 3, 2);

    // download ends in the middle of the second pixel
    build_file(2, 2, 24, 54, 8'h42, 1'b1);
    build_exp(2, 2, 24, 54);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    send(58, 0, 54);
    check_result(5'd16, 1'b0, 2, 2);

    // reset with a pixel queued and another half assembled
    build_file(2, 2, 24, 54, 8'h42, 1'b1);
    got_q.delete();
    ready_mode = 2;
    @(posedge clk_sys);
    #1;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    for (int i = 0; i < 59; i++) send_byte(25'(i), file_q[i]);
    check("pre_rst_valid", 32'(wr_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_width", 32'(img_width), 32'd2);
    @(posedge clk_sys);
    #1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    #1;
    check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_loaded", 32'(loaded), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_dims", {img_width, img_height}, 32'd0);
    reset = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk_sys);

    build_file(4, -3, 24, 54, 8'h42, 1'b1);
    build_exp(4, -3, 24, 54);
    send(-1, 1, 54);
    check_result(5'd0, 1'b1, 4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
